// File: rtl/inst_queue.sv
// Instruction queue decoupling if_stage from id_stage.
// Show-ahead FIFO with single-cycle flush on redirect.
module inst_queue #(
    parameter int DATA_WD = 66,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fs_to_iq_valid,
    input  logic [DATA_WD-1:0]         fs_to_iq_bus,
    output logic                       iq_allowin,
    output logic                       iq_to_ds_valid,
    output logic [DATA_WD-1:0]         iq_to_ds_bus,
    input  logic                       ds_allowin,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     iq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_WD-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    // allowin depends only on occupancy: no comb path decode -> fetch
    assign iq_allowin     = (count != FULL);
    assign iq_to_ds_valid = (count != '0);
    assign iq_to_ds_bus   = mem[rd_ptr];
    assign iq_count       = count;

    assign push = fs_to_iq_valid & iq_allowin & ~flush;
    assign pop  = iq_to_ds_valid & ds_allowin & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage carries no reset; contents are only visible while counted
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fs_to_iq_bus;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_queue;

    localparam int DW    = 66;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fs_to_iq_valid = 1'b0;
    logic [DW-1:0] fs_to_iq_bus = '0;
    logic          iq_allowin;
    logic          iq_to_ds_valid;
    logic [DW-1:0] iq_to_ds_bus;
    logic          ds_allowin = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    iq_count;

    inst_queue #(.DATA_WD(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_iq_valid (fs_to_iq_valid),
        .fs_to_iq_bus   (fs_to_iq_bus),
        .iq_allowin     (iq_allowin),
        .iq_to_ds_valid (iq_to_ds_valid),
        .iq_to_ds_bus   (iq_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .flush          (flush),
        .iq_count       (iq_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   pc_next = 32'h1c000000;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs(input string ph);
        check({ph, ".valid"}, DW'(iq_to_ds_valid), DW'(q.size() != 0));
        check({ph, ".allowin"}, DW'(iq_allowin), DW'(q.size() != DEPTH));
        check({ph, ".count"}, DW'(iq_count), DW'(q.size()));
        if (q.size() != 0)
            check({ph, ".bus"}, iq_to_ds_bus, q[0]);
    endtask

    function automatic logic [DW-1:0] mk(input logic ex, input logic num);
        logic [DW-1:0] e;
        e = {ex, num, pc_next, $urandom()};
        pc_next = pc_next + 32'd4;
        return e;
    endfunction

    task automatic step(input string ph, input logic v,
                        input logic [DW-1:0] d, input logic ds,
                        input logic fl);
        logic do_push;
        logic do_pop;
        @(negedge clk);
        compare_outputs(ph);
        fs_to_iq_valid = v;
        fs_to_iq_bus   = d;
        ds_allowin     = ds;
        flush          = fl;
        do_push = v && (q.size() != DEPTH) && !fl;
        do_pop  = (q.size() != 0) && ds && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
    endtask

    task automatic idle(input string ph, input logic ds);
        step(ph, 1'b0, '0, ds, 1'b0);
    endtask

    logic [DW-1:0] e5;
    logic [DW-1:0] bad;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 4; i++) step("t1", 1'b1, mk(1'b0, 1'b0), 1'b1, 1'b0);
        idle("t1", 1'b1);
        idle("t1", 1'b1);

        for (int i = 0; i < 4; i++) step("t2", 1'b1, mk(1'b0, 1'b0), 1'b0, 1'b0);
        e5 = mk(1'b0, 1'b0);
        step("t2", 1'b1, e5, 1'b0, 1'b0);
        step("t2", 1'b1, e5, 1'b0, 1'b0);

        step("t3", 1'b1, e5, 1'b1, 1'b0);
        step("t3", 1'b1, e5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t3", 1'b1, mk(1'b0, 1'b0), 1'b1, 1'b0);
        repeat (5) idle("t3", 1'b1);

        for (int i = 0; i < 3; i++) step("t4", 1'b1, mk(1'b0, 1'b0), 1'b0, 1'b0);
        bad = {2'b00, 32'h1c008000, 32'h0};
        step("t4", 1'b1, bad, 1'b0, 1'b1);
        idle("t4", 1'b1);
        idle("t4", 1'b1);

        step("t5", 1'b1, mk(1'b0, 1'b0), 1'b1, 1'b0);
        step("t5", 1'b1, mk(1'b1, 1'b1), 1'b1, 1'b0);
        step("t5", 1'b1, mk(1'b0, 1'b1), 1'b1, 1'b0);
        step("t5", 1'b1, mk(1'b1, 1'b0), 1'b1, 1'b0);
        idle("t5", 1'b1);

        step("t6", 1'b1, mk(1'b0, 1'b0), 1'b0, 1'b0);
        step("t6", 1'b1, mk(1'b0, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        compare_outputs("t6pre");
        fs_to_iq_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        q.delete();
        compare_outputs("t6async");
        @(negedge clk);
        reset = 1'b0;
        idle("t6", 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic v, ds, fl;
            logic [DW-1:0] d;
            int bias;
            bias = (i / 300) % 4;
            v  = ($urandom_range(3, 0) < 3 - (bias == 1 ? 2 : 0));
            ds = ($urandom_range(3, 0) < 1 + (bias == 2 ? 2 : 0));
            fl = ($urandom_range(15, 0) == 0);
            d  = mk(1'($urandom()), 1'($urandom()));
            step("rand", v, d, ds, fl);
        end
        @(negedge clk);
        compare_outputs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
